logic_op_serializer: RTL and testbench

LOGIC_OP_SERIALIZER -- requirements
Module: logic_op_serializer

---
 rtl/logic_op_serializer.sv | 83 ++++++++
 tb/tb_logic_op_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_serializer.sv
// logic_op_serializer: streams one result beat per logic operator of a captured operand pair; define LOGIC_OP_SERIALIZER_LOGICAL_EN for codes 5-7
module logic_op_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [7:0]       out_seq
);
`ifdef LOGIC_OP_SERIALIZER_LOGICAL_EN
  localparam logic [2:0] LAST_OP = 3'd7;
`else
  localparam logic [2:0] LAST_OP = 3'd4;
`endif
  typedef enum logic {IDLE, EMIT} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [7:0]       seq_cnt;
  logic [2:0]       next_op;
  function automatic logic [WIDTH-1:0] calc(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef LOGIC_OP_SERIALIZER_LOGICAL_EN
    calc = op == 3'd0 ? ~a :
           op == 3'd1 ? a & b :
           op == 3'd2 ? a | b :
           op == 3'd3 ? a ^ b :
           op == 3'd4 ? ~(a ^ b) :
           op == 3'd5 ? WIDTH'(!a) :
           op == 3'd6 ? WIDTH'(a && b) :
                        WIDTH'(a || b);
`else
    calc = op == 3'd0 ? ~a :
           op == 3'd1 ? a & b :
           op == 3'd2 ? a | b :
           op == 3'd3 ? a ^ b :
                        ~(a ^ b);
`endif
  endfunction
  assign in_ready = state == IDLE && !rst;
  assign next_op  = out_op + 3'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      seq_cnt   <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_seq   <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state     <= EMIT;
        a_r       <= in_a;
        b_r       <= in_b;
        seq_cnt   <= seq_cnt + 8'd1;
        out_valid <= 1'b1;
        out_op    <= 3'd0;
        out_data  <= calc(3'd0, in_a, in_b);
        out_last  <= 1'b0;
        out_seq   <= seq_cnt;
      end
    end else if (out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        out_op   <= next_op;
        out_data <= calc(next_op, a_r, b_r);
        out_last <= next_op == LAST_OP;
      end
    end
  end
endmodule

// File: tb/tb_logic_op_serializer.sv
// tb_logic_op_serializer: directed self-checking bench for logic_op_serializer
module tb_logic_op_serializer;
`ifdef LOGIC_OP_SERIALIZER_LOGICAL_EN
  localparam int N = 8;
`else
  localparam int N = 5;
`endif
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [3:0] in_a, in_b, out_data;
  logic [2:0] out_op;
  logic [7:0] out_seq;
  logic [3:0] exp_d [8];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  logic_op_serializer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_data(out_data), .out_last(out_last), .out_seq(out_seq)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic drain;
    int t = 0;
    out_ready = 1'b1;
    while (out_valid && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain out_valid got %b want 0", out_valid);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, out_op, out_data, out_last, out_seq} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b op=%0d d=%b l=%b s=%0d want all 0", in_ready, out_valid, out_op, out_data, out_last, out_seq);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got %b want 1", in_ready);
    end
  endtask
  task automatic test_pair(input logic [3:0] a, input logic [3:0] b, input logic [7:0] seq);
    out_ready = 1'b1;
    offer(a, b);
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({out_valid, out_op, out_data, out_last, out_seq} !== {1'b1, 3'(i), exp_d[i], 1'(i == N - 1), seq}) begin
        errors++;
        $display("FAIL pair_beat%0d got v=%b op=%0d d=%b l=%b s=%0d want v=1 op=%0d d=%b l=%b s=%0d",
                 i, out_valid, out_op, out_data, out_last, out_seq, i, exp_d[i], i == N - 1, seq);
      end
      tick();
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL pair_end got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask
  task automatic test_stall;
    int k = 0;
    int c = 0;
    exp_d = '{4'b1111, 4'b0000, 4'b0101, 4'b0101, 4'b1010, 4'b0001, 4'b0000, 4'b0001};
    out_ready = 1'b1;
    offer(4'b0000, 4'b0101);
    while (k < N && c < 40) begin
      out_ready = c % 2 == 0;
      checks++;
      if ({out_valid, out_op, out_data, out_last, out_seq} !== {1'b1, 3'(k), exp_d[k], 1'(k == N - 1), 8'd2}) begin
        errors++;
        $display("FAIL stall_beat%0d cyc%0d got v=%b op=%0d d=%b l=%b s=%0d want v=1 op=%0d d=%b l=%b s=2",
                 k, c, out_valid, out_op, out_data, out_last, out_seq, k, exp_d[k], k == N - 1);
      end
      if (out_ready) k++;
      tick();
      c++;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end out_valid got %b want 0", out_valid);
    end
  endtask
  task automatic test_ignore_during_emit;
    exp_d = '{4'b1011, 4'b0000, 4'b0111, 4'b0111, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    out_ready = 1'b1;
    offer(4'b0100, 4'b0011);
    in_valid = 1'b1;
    in_a = 4'b1111;
    in_b = 4'b1111;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({in_ready, out_op, out_data, out_seq} !== {1'b0, 3'(i), exp_d[i], 8'd3}) begin
        errors++;
        $display("FAIL ignore_beat%0d got rdy=%b op=%0d d=%b s=%0d want rdy=0 op=%0d d=%b s=3",
                 i, in_ready, out_op, out_data, out_seq, i, exp_d[i]);
      end
      tick();
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ignore_idle got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_op, out_data, out_seq} !== {1'b1, 3'd0, 4'b0000, 8'd4}) begin
      errors++;
      $display("FAIL ignore_late_accept got v=%b op=%0d d=%b s=%0d want v=1 op=0 d=0000 s=4", out_valid, out_op, out_data, out_seq);
    end
    tick();
    checks++;
    if (out_data !== 4'b1111) begin
      errors++;
      $display("FAIL ignore_late_and got %b want 1111", out_data);
    end
    drain();
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b1;
    offer(4'b0100, 4'b0011);
    tick();
    tick();
    tick();
    checks++;
    if ({out_valid, out_op} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL rstmid_beat3 got v=%b op=%0d want v=1 op=3", out_valid, out_op);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready, out_seq} !== 10'd0) begin
      errors++;
      $display("FAIL rstmid_abandon got v=%b rdy=%b s=%0d want 0 0 0", out_valid, in_ready, out_seq);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b want 1", in_ready);
    end
    offer(4'b0100, 4'b0011);
    checks++;
    if ({out_valid, out_data, out_seq} !== {1'b1, 4'b1011, 8'd0}) begin
      errors++;
      $display("FAIL rstmid_restart got v=%b d=%b s=%0d want v=1 d=1011 s=0", out_valid, out_data, out_seq);
    end
    drain();
  endtask
  task automatic test_wrap;
    out_ready = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      offer(k[3:0], ~k[3:0]);
      checks++;
      if (out_seq !== 8'(k)) begin
        errors++;
        $display("FAIL wrap_seq pair%0d got %0d want %0d", k, out_seq, k % 256);
      end
      drain();
    end
  endtask
  initial begin
    test_reset();
    exp_d = '{4'b1011, 4'b0000, 4'b0111, 4'b0111, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    test_pair(4'b0100, 4'b0011, 8'd0);
    exp_d = '{4'b1011, 4'b0100, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 4'b0001, 4'b0001};
    test_pair(4'b0100, 4'b0100, 8'd1);
    test_stall();
    test_ignore_during_emit();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
